// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring
// divide, fixed 34-cycle issue-to-issue cadence with a one-cycle done pulse.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        armed;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic [31:0] a_raw;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] m;
  logic        neg_q;
  logic        neg_r;
  logic        div0;

  logic        accept;
  logic        in_div;
  logic        a_sg;
  logic        b_sg;
  logic        a_ng;
  logic        b_ng;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [32:0] sum;
  logic [32:0] r33;
  logic [33:0] diff;
  logic        ge;

  logic [63:0] prod;
  logic [63:0] prod_s;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] fin;

  // armed blocks a start that coincides with the reset-release edge
  assign accept = (state == IDLE) && start && armed;

  assign in_div = funct3[2];
  assign a_sg   = in_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_sg   = in_div ? ~funct3[0] : ~funct3[1];
  assign a_ng   = a_sg & op_a[31];
  assign b_ng   = b_sg & op_b[31];
  assign a_mag  = a_ng ? (32'd0 - op_a) : op_a;
  assign b_mag  = b_ng ? (32'd0 - op_b) : op_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (cnt == 5'd31) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
    r33  = {hi, lo[31]};
    diff = {1'b0, r33} - {2'b00, m};
    ge   = ~diff[33];
  end

  always_comb begin
    prod   = {hi, lo};
    prod_s = neg_q ? (64'd0 - prod) : prod;
    q_s    = neg_q ? (32'd0 - lo) : lo;
    r_s    = neg_r ? (32'd0 - hi) : hi;
    fin    = 32'd0;
    unique case (1'b1)
      !op[2]:
        fin = (op[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
      op[2] && div0:
        fin = op[1] ? a_raw : 32'hFFFF_FFFF;
      default:
        fin = op[1] ? r_s : q_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op     <= '0;
      rd_q   <= '0;
      a_raw  <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            op    <= funct3;
            rd_q  <= rd_in;
            a_raw <= op_a;
            hi    <= '0;
            neg_q <= a_ng ^ b_ng;
            neg_r <= a_ng;
            div0  <= (op_b == 32'd0);
            lo    <= in_div ? a_mag : b_mag;
            m     <= in_div ? b_mag : a_mag;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (!op[2]) begin
            hi <= sum[32:1];
            lo <= {sum[0], lo[31:1]};
          end else if (ge) begin
            hi <= diff[31:0];
            lo <= {lo[30:0], 1'b1};
          end else begin
            hi <= r33[31:0];
            lo <= {lo[30:0], 1'b0};
          end
        end
        DONE: begin
          done   <= 1'b1;
          result <= fin;
          rd_out <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign we   = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an
// arithmetic reference model of the RV32M operations.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we;

  int n_chk = 0;
  int n_err = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we     (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib, r;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    r   = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        r = ia / ib;
        return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        r = ia % ib;
        return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // called at a negedge; returns at the negedge of the done cycle
  task automatic do_op(input logic [2:0]  f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0]  rd,
                       input bit          noise);
    logic [31:0] exp;
    exp    = model(f, a, b);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    start  = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      start  = noise && (i == 5 || i == 20);
      funct3 = 3'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
      rd_in  = 5'($urandom);
      if (i == 32) begin
        start = 1'b0;
        chk("busy_calc", 32'(busy), 32'd1);
        chk("early_done", 32'(done), 32'd0);
      end
      @(posedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("result", result, exp);
    chk("rd_out", 32'(rd_out), 32'(rd));
    chk("we", 32'(we), 32'(rd != 5'd0));
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    bit seen;
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    chk("mul_7x-3", result, 32'hFFFF_FFEB);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b0);
    do_op(3'd4, 32'd5, 32'd0, 5'd4, 1'b0);
    do_op(3'd7, 32'd5, 32'd0, 5'd6, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);
    chk("div_-7/2", result, 32'hFFFF_FFFD);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
    chk("rem_-7/2", result, 32'hFFFF_FFFF);
    do_op(3'd0, 32'd9, 32'd11, 5'd0, 1'b0);
    do_op(3'd5, 32'd1000, 32'd33, 5'd11, 1'b0);
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
    chk("result_hold", result, 32'd30);

    do_op(3'd0, 32'd123, 32'd456, 5'd12, 1'b1);

    @(negedge clk);
    funct3 = 3'd0;
    op_a   = 32'd3;
    op_b   = 32'd5;
    rd_in  = 5'd13;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b1;
    funct3 = 3'd5;
    op_a   = 32'd100;
    op_b   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    chk("start_at_release", 32'(busy), 32'd0);
    start = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || we) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    do_op(3'd5, 32'd100, 32'd7, 5'd3, 1'b0);
    chk("divu_100/7", result, 32'd14);

    for (int k = 0; k < 60; k++)
      do_op(3'($urandom), pick(), pick(),
            5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
